prog_loader: RTL and testbench

Program loader that fills the processor's 32-word instruction memory before execution, then releases the processor through its `Run` input. It accepts a 16-bit instruction stream as 4-bit nibbles over a valid/ready handshake, most significant nibble first. It packs each word and writes it to sequential instruction-memory addresses starting at 0. The processor's fetch path is the reader of this memory; this block is the writer.

---
 rtl/prog_loader.sv | 88 ++++++++
 tb/tb_prog_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Instruction-memory loader: packs a 4-bit nibble stream into 16-bit words, writes them
// to sequential addresses from 0, then raises Run to release the processor.
module prog_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W:0]   Count,
  input  logic              Nib_valid,
  input  logic [3:0]        Nib,
  output logic              Nib_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wren,
  output logic              Busy,
  output logic              Run
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_RUN} state_t;

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  state_t              r_state;
  logic [ADDR_W:0]     r_words_left;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_nib_cnt;
  logic [DATA_W-1:0]   r_buf;
  logic [DATA_W-1:0]   r_wr_data;
  logic [ADDR_W-1:0]   r_wr_addr;

  logic [ADDR_W:0]     w_load_cnt;
  logic [DATA_W-1:0]   w_shift;

  assign w_load_cnt = (Count > MAX_WORDS) ? MAX_WORDS : Count;
  assign w_shift    = {r_buf[DATA_W-5:0], Nib};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_words_left <= '0;
      r_addr       <= '0;
      r_nib_cnt    <= '0;
      r_buf        <= '0;
      r_wr_data    <= '0;
      r_wr_addr    <= '0;
    end else begin
      case (r_state)
        // A Start in RUN restarts the load exactly as from IDLE.
        S_IDLE, S_RUN: begin
          if (Start) begin
            r_words_left <= w_load_cnt;
            r_addr       <= '0;
            r_nib_cnt    <= '0;
            r_state      <= (Count == '0) ? S_RUN : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (Nib_valid) begin
            r_buf     <= w_shift;
            r_nib_cnt <= r_nib_cnt + 2'd1;
            if (r_nib_cnt == 2'd3) begin
              r_state   <= S_WRITE;
              r_wr_addr <= r_addr;
              r_wr_data <= w_shift;
            end
          end
        end
        S_WRITE: begin
          r_addr       <= r_addr + ADDR_W'(1);
          r_words_left <= r_words_left - (ADDR_W+1)'(1);
          r_state      <= (r_words_left == (ADDR_W+1)'(1)) ? S_RUN : S_COLLECT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write address/data are captured on entry to WRITE and hold afterwards; wren qualifies them.
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign wren      = (r_state == S_WRITE);
  assign Nib_ready = (r_state == S_COLLECT);
  assign Busy      = (r_state == S_COLLECT) || (r_state == S_WRITE);
  assign Run       = (r_state == S_RUN);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: write logger plus hand-computed expectations.
module tb_prog_loader;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  logic              Clock;
  logic              Reset;
  logic              Start;
  logic [ADDR_W:0]   Count;
  logic              Nib_valid;
  logic [3:0]        Nib;
  logic              Nib_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wren;
  logic              Busy;
  logic              Run;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [32];
  int wcyc [64];
  int nwr = 0;
  int cyc = 0;

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Count(Count),
    .Nib_valid(Nib_valid), .Nib(Nib), .Nib_ready(Nib_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wren(wren),
    .Busy(Busy), .Run(Run)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Memory model: captures every qualified write and the cycle it happened in.
  always @(posedge Clock) begin
    cyc++;
    if (wren) begin
      mem[wr_addr] = wr_data;
      if (nwr < 64) wcyc[nwr] = cyc;
      nwr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Streams one word MS nibble first; returns in the WRITE cycle with junk left on Nib.
  task automatic send_word(input logic [15:0] w, input int gap);
    for (int k = 3; k >= 0; k--) begin
      if (gap > 0) begin
        Nib_valid = 1'b0;
        repeat (gap) tick();
      end
      Nib_valid = 1'b1;
      Nib = w[k*4 +: 4];
      tick();
    end
    Nib = 4'hF;
  endtask

  task automatic start_load(input logic [ADDR_W:0] cnt);
    Start = 1'b1;
    Count = cnt;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    int n0;
    logic [15:0] w;

    Reset = 1'b1; Start = 1'b0; Count = '0; Nib_valid = 1'b0; Nib = 4'h0;
    #12;
    chk("rst_nib_ready", 32'(Nib_ready), 32'h0);
    chk("rst_wren", 32'(wren), 32'h0);
    chk("rst_run", 32'(Run), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    @(posedge Clock); #1;
    Reset = 1'b0;

    // Idle with valid asserted and no Start: nothing moves.
    Nib_valid = 1'b1; Nib = 4'h5;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_quiet", {28'h0, Nib_ready, wren, Run, Busy}, 32'h0);
    end
    chk("idle_no_wr", 32'(nwr), 32'h0);

    // Two words, continuous valid; the nibble present with Start must be dropped.
    Nib = 4'hF;
    start_load(7'd2);
    chk("l2_busy", 32'(Busy), 32'h1);
    chk("l2_ready", 32'(Nib_ready), 32'h1);
    send_word(16'h1234, 0);
    chk("l2_w0_wren", 32'(wren), 32'h1);
    chk("l2_w0_addr", 32'(wr_addr), 32'h0);
    chk("l2_w0_data", 32'(wr_data), 32'h1234);
    chk("l2_w0_ready", 32'(Nib_ready), 32'h0);
    tick();
    chk("l2_hold_data", 32'(wr_data), 32'h1234);
    chk("l2_hold_wren", 32'(wren), 32'h0);
    send_word(16'hABCD, 0);
    chk("l2_w1_wren", 32'(wren), 32'h1);
    chk("l2_w1_addr", 32'(wr_addr), 32'h1);
    chk("l2_w1_data", 32'(wr_data), 32'hABCD);
    tick();
    chk("l2_run", 32'(Run), 32'h1);
    chk("l2_busy_low", 32'(Busy), 32'h0);
    chk("l2_nwr", 32'(nwr), 32'd2);
    chk("l2_spacing", 32'(wcyc[1] - wcyc[0]), 32'd5);
    chk("l2_mem0", 32'(mem[0]), 32'h1234);
    chk("l2_mem1", 32'(mem[1]), 32'hABCD);

    // Same stream with 3-cycle gaps, restarted from RUN.
    start_load(7'd2);
    chk("gap_run_drop", 32'(Run), 32'h0);
    n0 = nwr;
    send_word(16'h1234, 3);
    chk("gap_no_early_wr", 32'(nwr), 32'(n0));
    chk("gap_w0_addr", 32'(wr_addr), 32'h0);
    chk("gap_w0_data", 32'(wr_data), 32'h1234);
    tick();
    send_word(16'hABCD, 3);
    chk("gap_w1_wren", 32'(wren), 32'h1);
    chk("gap_w1_addr", 32'(wr_addr), 32'h1);
    chk("gap_w1_data", 32'(wr_data), 32'hABCD);
    tick();
    chk("gap_run", 32'(Run), 32'h1);
    chk("gap_nwr", 32'(nwr - n0), 32'd2);

    // Count=40 saturates to 32 words at addresses 0..31.
    start_load(7'd40);
    n0 = nwr;
    for (int i = 0; i < 32; i++) begin
      w = 16'(i * 16'h0421 + 16'h0F0F);
      send_word(w, 0);
      chk("sat_addr", 32'(wr_addr), 32'(i));
      chk("sat_data", 32'(wr_data), 32'(w));
      tick();
    end
    chk("sat_run", 32'(Run), 32'h1);
    chk("sat_busy", 32'(Busy), 32'h0);
    repeat (3) tick();
    chk("sat_nwr", 32'(nwr - n0), 32'd32);
    chk("sat_mem31", 32'(mem[31]), 32'(16'(31 * 16'h0421 + 16'h0F0F)));
    chk("sat_mem0", 32'(mem[0]), 32'h0F0F);

    // Count=0 from IDLE, then a one-word load restarted from RUN.
    Reset = 1'b1; #2; Reset = 1'b0;
    tick();
    chk("c0_pre_run", 32'(Run), 32'h0);
    n0 = nwr;
    start_load(7'd0);
    chk("c0_run", 32'(Run), 32'h1);
    chk("c0_busy", 32'(Busy), 32'h0);
    repeat (2) tick();
    chk("c0_no_wr", 32'(nwr), 32'(n0));
    start_load(7'd1);
    chk("c1_run_drop", 32'(Run), 32'h0);
    send_word(16'hBEEF, 0);
    chk("c1_addr", 32'(wr_addr), 32'h0);
    chk("c1_data", 32'(wr_data), 32'hBEEF);
    tick();
    chk("c1_run", 32'(Run), 32'h1);
    chk("c1_nwr", 32'(nwr - n0), 32'd1);

    // Reset after 6 nibbles of a 3-word load.
    start_load(7'd3);
    n0 = nwr;
    send_word(16'h1111, 0);
    tick();
    Nib_valid = 1'b1; Nib = 4'h2; tick();
    Nib = 4'h3; tick();
    Nib_valid = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_out", {24'h0, Nib_ready, wren, Run, Busy, 4'h0}, 32'h0);
    chk("mid_rst_addr", 32'(wr_addr), 32'h0);
    chk("mid_rst_data", 32'(wr_data), 32'h0);
    tick();
    Reset = 1'b0;
    repeat (3) tick();
    chk("mid_rst_run", 32'(Run), 32'h0);
    chk("mid_rst_nwr", 32'(nwr - n0), 32'd1);
    start_load(7'd1);
    send_word(16'h7777, 0);
    chk("fresh_addr", 32'(wr_addr), 32'h0);
    chk("fresh_data", 32'(wr_data), 32'h7777);
    tick();
    chk("fresh_run", 32'(Run), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
